// File: rtl/decode_stage.sv
// Registered instruction decode stage with a per-register pending-write scoreboard
// that stalls read-after-write hazards, and valid/ready handshakes on both sides.
module decode_stage #(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         alu_op,
  output logic [REG_AW-1:0]  rd,
  output logic [REG_AW-1:0]  rs1,
  output logic [REG_AW-1:0]  rs2,
  output logic [XLEN-1:0]    immediate,
  output logic               is_imm_op,
  output logic               illegal,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic               flush
);

  localparam int IMM_W    = INSTR_W - 4 - 3 * REG_AW;
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam logic [NUM_REGS-1:0] REG0_BIT  = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] NO_REGS   = {NUM_REGS{1'b0}};
  localparam logic [REG_AW-1:0]   REG_ZERO  = {REG_AW{1'b0}};

  logic [3:0]          f_op;
  logic [REG_AW-1:0]   f_rd;
  logic [REG_AW-1:0]   f_rs1;
  logic [REG_AW-1:0]   f_rs2;
  logic [IMM_W-1:0]    f_imm;
  logic [XLEN-1:0]     f_imm_ext;
  logic [2:0]          dec_alu;
  logic                dec_imm;
  logic                dec_ill;
  logic                use_rs1;
  logic                use_rs2;
  logic                dec_writes;
  logic                held_writes;
  logic                hazard;
  logic                accept;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_eff;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] flush_mask;
  logic [NUM_REGS-1:0] set_mask;

  assign f_op      = instruction[INSTR_W-1 -: 4];
  assign f_rd      = instruction[INSTR_W-5 -: REG_AW];
  assign f_rs1     = instruction[INSTR_W-5-REG_AW -: REG_AW];
  assign f_rs2     = instruction[INSTR_W-5-2*REG_AW -: REG_AW];
  assign f_imm     = instruction[IMM_W-1:0];
  assign f_imm_ext = {{(XLEN-IMM_W){f_imm[IMM_W-1]}}, f_imm};

  // Opcode table: ALU operation, immediate select and which sources are read
  always_comb begin
    dec_alu = 3'b000;
    dec_imm = 1'b0;
    dec_ill = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (f_op)
      4'd0: dec_alu = 3'b000;
      4'd1: begin dec_alu = 3'b010; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      4'd2: begin dec_alu = 3'b011; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      4'd3: begin dec_alu = 3'b100; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      4'd4: begin dec_alu = 3'b101; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      4'd5: begin dec_alu = 3'b110; dec_imm = 1'b1; use_rs1 = 1'b1; end
      4'd6: begin dec_alu = 3'b111; dec_imm = 1'b1; use_rs1 = 1'b1; end
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_writes  = ~dec_ill & (f_op != 4'd0) & (f_rd != REG_ZERO);
  // Only NOOP and illegal opcodes decode to alu_op 000, so a nonzero held alu_op means a register write
  assign held_writes = out_valid & (alu_op != 3'b000) & (rd != REG_ZERO);

  assign wb_mask    = wb_valid ? (REG0_BIT << wb_rd) : NO_REGS;
  assign flush_mask = (flush & held_writes) ? (REG0_BIT << rd) : NO_REGS;
  assign set_mask   = (accept & dec_writes) ? (REG0_BIT << f_rd) : NO_REGS;

  assign pend_eff    = pending & ~wb_mask;
  assign hazard      = in_valid & ((use_rs1 & pend_eff[f_rs1]) | (use_rs2 & pend_eff[f_rs2]));
  assign in_ready    = (~out_valid | out_ready) & ~hazard & ~flush;
  assign accept      = in_valid & in_ready;
  // Set is applied last so a same-cycle accept wins over writeback of the same register
  assign pending_nxt = ((pend_eff & ~flush_mask) | set_mask) & ~REG0_BIT;

  // Pending-write scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= NO_REGS;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Decoded output register; fields only change on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_op    <= 3'b000;
      rd        <= REG_ZERO;
      rs1       <= REG_ZERO;
      rs2       <= REG_ZERO;
      immediate <= {XLEN{1'b0}};
      is_imm_op <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_op    <= dec_alu;
      rd        <= f_rd;
      rs1       <= f_rs1;
      rs2       <= f_rs2;
      immediate <= f_imm_ext;
      is_imm_op <= dec_imm;
      illegal   <= dec_ill;
    end else if (flush | out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a spec-level model predicts in_ready, out_valid and
// the pending set each cycle, and queues expected decodes for a separate output monitor.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] immediate;
  logic        is_imm_op;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  decode_stage #(.INSTR_W(32), .REG_AW(5), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .is_imm_op(is_imm_op), .illegal(illegal), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush)
  );

  typedef struct {
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        isimm;
    logic        ill;
    logic        wr;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  bit          running = 1'b0;
  txn_t        sb[$];
  logic [31:0] m_pend;
  logic [31:0] np;
  logic [31:0] pe;
  bit          m_ov;
  bit          exp_rdy;
  bit          hz;
  bit          acc;
  bit          use1;
  bit          use2;
  int          op;
  txn_t        mt;
  txn_t        ht;
  txn_t        nt;
  bit          prev_hold;
  logic [22:0] snap_a;
  logic [31:0] snap_imm;
  logic [3:0]  r_op;
  logic        r_fl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] o, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [12:0] im);
    return {o, d, s1, s2, im};
  endfunction

  // Spec-level decode: table lookup and signed arithmetic on the immediate
  function automatic txn_t decode(input logic [31:0] ins);
    txn_t d;
    int   o;
    int   imm;
    o   = int'(ins[31:28]);
    imm = int'(ins[12:0]);
    if (imm >= 4096) imm = imm - 8192;
    d.rd    = ins[27:23];
    d.rs1   = ins[22:18];
    d.rs2   = ins[17:13];
    d.imm   = imm;
    d.ill   = (o >= 7);
    d.alu   = (o >= 1 && o <= 6) ? 3'(o + 1) : 3'd0;
    d.isimm = (o == 5 || o == 6);
    d.wr    = (o >= 1 && o <= 6) && (d.rd != 5'd0);
    return d;
  endfunction

  task automatic model_clear();
    sb.delete();
    m_pend    = 32'd0;
    m_ov      = 1'b0;
    prev_hold = 1'b0;
  endtask

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic ordy,
                     input logic wv, input logic [4:0] wr, input logic fl);
    in_valid    = iv;
    instruction = ins;
    out_ready   = ordy;
    wb_valid    = wv;
    wb_rd       = wr;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: predicts handshake and scoreboard, queues expected decodes
  always @(negedge clk) begin
    if (running) begin
      op   = int'(instruction[31:28]);
      use1 = (op >= 1 && op <= 6);
      use2 = (op >= 1 && op <= 4);
      pe   = m_pend;
      if (wb_valid) pe[wb_rd] = 1'b0;
      hz      = in_valid && ((use1 && pe[instruction[22:18]]) || (use2 && pe[instruction[17:13]]));
      exp_rdy = (!m_ov || out_ready) && !hz && !flush;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("pending", dut.pending, m_pend);
      acc = in_valid && exp_rdy;
      np  = m_pend;
      if (wb_valid) np[wb_rd] = 1'b0;
      if (flush && m_ov && sb.size() > 0) begin
        ht = sb.pop_front();
        if (ht.wr) np[ht.rd] = 1'b0;
      end
      if (acc) begin
        nt = decode(instruction);
        sb.push_back(nt);
        if (nt.wr) np[nt.rd] = 1'b1;
      end
      np[0]  = 1'b0;
      m_pend = np;
      if (acc) m_ov = 1'b1;
      else if (flush || out_ready) m_ov = 1'b0;
    end
  end

  // Output monitor: pops on every downstream handshake, checks hold stability
  always @(negedge clk) begin
    if (running) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=1 required=0");
        end else begin
          mt = sb.pop_front();
          chk("alu_op", 32'(alu_op), 32'(mt.alu));
          chk("rd", 32'(rd), 32'(mt.rd));
          chk("rs1", 32'(rs1), 32'(mt.rs1));
          chk("rs2", 32'(rs2), 32'(mt.rs2));
          chk("immediate", immediate, mt.imm);
          chk("is_imm_op", 32'(is_imm_op), 32'(mt.isimm));
          chk("illegal", 32'(illegal), 32'(mt.ill));
        end
      end
      if (prev_hold) begin
        chk("hold_fields", 32'({alu_op, rd, rs1, rs2, is_imm_op, illegal}), 32'(snap_a));
        chk("hold_imm", immediate, snap_imm);
      end
      prev_hold = out_valid && !out_ready;
      snap_a    = {alu_op, rd, rs1, rs2, is_imm_op, illegal};
      snap_imm  = immediate;
    end
  end

  initial begin
    rst_n = 1'b0;
    model_clear();
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_immediate", immediate, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_pending", dut.pending, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    running = 1'b1;

    // T2: ADDI rd=1 with all-ones immediate, then an illegal opcode
    cyc(1'b1, mk(4'd5, 5'd1, 5'd2, 5'd0, 13'h1FFF), 1'b1, 1'b0, 5'd0, 1'b0);
    chk("t2_alu", 32'(alu_op), 32'd6);
    chk("t2_imm", immediate, 32'hFFFF_FFFF);
    chk("t2_is_imm", 32'(is_imm_op), 32'd1);
    chk("t2_legal", 32'(illegal), 32'd0);
    cyc(1'b1, mk(4'd15, 5'd2, 5'd0, 5'd0, 13'h0123), 1'b1, 1'b0, 5'd0, 1'b0);
    chk("t2_illegal", 32'(illegal), 32'd1);
    chk("t2_ill_alu", 32'(alu_op), 32'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 1'b0);

    // T3: RAW on r3 stalls until its writeback, accepted in that same cycle
    cyc(1'b1, mk(4'd1, 5'd3, 5'd0, 5'd0, 13'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    repeat (3) cyc(1'b1, mk(4'd2, 5'd4, 5'd3, 5'd0, 13'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    chk("t3_pend3", 32'(dut.pending[3]), 32'd1);
    chk("t3_stalled", 32'(out_valid), 32'd0);
    cyc(1'b1, mk(4'd2, 5'd4, 5'd3, 5'd0, 13'd0), 1'b1, 1'b1, 5'd3, 1'b0);
    chk("t3_accepted", 32'(out_valid), 32'd1);
    chk("t3_rs1", 32'(rs1), 32'd3);

    // T4: eight independent ADDs back to back, then three cycles of backpressure
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, mk(4'd1, 5'(10 + i), 5'd0, 5'd0, 13'(i)), 1'b1, 1'b0, 5'd0, 1'b0);
    repeat (3) cyc(1'b1, mk(4'd1, 5'd20, 5'd0, 5'd0, 13'd0), 1'b0, 1'b0, 5'd0, 1'b0);
    chk("t4_last_rd", 32'(rd), 32'd17);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);

    // T5: accept ADD rd=4 while r4 is written back
    cyc(1'b1, mk(4'd1, 5'd4, 5'd0, 5'd0, 13'd0), 1'b1, 1'b1, 5'd4, 1'b0);
    chk("t5_pend4", 32'(dut.pending[4]), 32'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);

    // T6: flush a held ADD rd=7, then a reader of r7 goes straight through
    cyc(1'b1, mk(4'd1, 5'd7, 5'd0, 5'd0, 13'd0), 1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_pend7", 32'(dut.pending[7]), 32'd0);
    cyc(1'b1, mk(4'd2, 5'd8, 5'd7, 5'd7, 13'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    chk("t6_accepted", 32'(out_valid), 32'd1);

    // T1: asynchronous reset with an instruction in flight
    cyc(1'b1, mk(4'd1, 5'd9, 5'd0, 5'd0, 13'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    #2;
    running = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_pending", dut.pending, 32'd0);
    chk("t1_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    running = 1'b1;

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      r_op = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
      r_fl = ($urandom_range(0, 19) == 0);
      cyc(($urandom_range(0, 3) != 0),
          mk(r_op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 13'($urandom)),
          r_fl ? 1'b0 : ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), r_fl);
    end
    repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
